// File: rtl/csr_sequencer_if.sv
// Core/CSR-file side bundle of csr_sequencer: instruction request, writeback,
// PC redirect and the CSR-file access port. Names are from the sequencer's view.
interface csr_sequencer_if;
    // core request
    logic        start_i;
    logic [1:0]  sys_op_i;
    logic [2:0]  funct3_i;
    logic [11:0] csr_sel_i;
    logic [4:0]  rs1_idx_i;
    logic [31:0] rs1_val_i;
    logic [31:0] pc_i;
    // core response
    logic        busy_o;
    logic        done_o;
    logic        rd_we_o;
    logic [31:0] rd_data_o;
    logic        redirect_o;
    logic [31:0] new_pc_o;
    // CSR-file port
    logic [11:0] csr_addr_o;
    logic [31:0] csr_bus_o;
    logic        csr_read_o;
    logic        csr_write_o;
    logic [1:0]  csr_write_type_o;
    logic        csr_trap_o;
    logic [4:0]  csr_trap_cause_o;
    logic        csr_ret_o;
    logic [31:0] csr_rdata_i;
    logic        csr_invalid_i;

    modport slave (
        input  start_i, sys_op_i, funct3_i, csr_sel_i, rs1_idx_i, rs1_val_i, pc_i,
        input  csr_rdata_i, csr_invalid_i,
        output busy_o, done_o, rd_we_o, rd_data_o, redirect_o, new_pc_o,
        output csr_addr_o, csr_bus_o, csr_read_o, csr_write_o, csr_write_type_o,
        output csr_trap_o, csr_trap_cause_o, csr_ret_o
    );

    modport master (
        output start_i, sys_op_i, funct3_i, csr_sel_i, rs1_idx_i, rs1_val_i, pc_i,
        output csr_rdata_i, csr_invalid_i,
        input  busy_o, done_o, rd_we_o, rd_data_o, redirect_o, new_pc_o,
        input  csr_addr_o, csr_bus_o, csr_read_o, csr_write_o, csr_write_type_o,
        input  csr_trap_o, csr_trap_cause_o, csr_ret_o
    );
endinterface

// File: rtl/csr_sequencer.sv
// Multi-cycle sequencer for CSR instructions, ECALL/EBREAK traps and MRET.
// Optional macro CSR_RS1_ZERO_SKIP_EN: set/clear forms with rs1==x0 skip the write cycle.
module csr_sequencer (
    input  logic            clk,
    input  logic            rst,
    csr_sequencer_if.slave  bus
);

    localparam logic [4:0]  ILLEGAL_CAUSE = 5'd2;
    localparam logic [4:0]  ECALL_CAUSE   = 5'd11;
    localparam logic [4:0]  EBREAK_CAUSE  = 5'd3;
    localparam logic [11:0] MTVEC_ADDR    = 12'h305;
    localparam logic [11:0] MEPC_ADDR     = 12'h341;

    localparam logic [1:0]  OP_CSR    = 2'b00;
    localparam logic [1:0]  OP_ECALL  = 2'b01;
    localparam logic [1:0]  OP_EBREAK = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_TRAP,
        S_VEC,
        S_RET,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  sys_op_q, sys_op_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [11:0] csr_sel_q, csr_sel_d;
    logic [4:0]  rs1_idx_q, rs1_idx_d;
    logic [31:0] rs1_val_q, rs1_val_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] old_q, old_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic        trapped_q, trapped_d;

    logic        skip_wr;
    logic        csr_ok;
    logic [4:0]  trap_cause;

`ifdef CSR_RS1_ZERO_SKIP_EN
    // CSRRS/CSRRC(I) with a zero source only read, so the write cycle is dropped.
    assign skip_wr = funct3_q[1] && (rs1_idx_q == 5'd0);
`else
    assign skip_wr = 1'b0;
`endif

    assign csr_ok = (sys_op_q == OP_CSR) && !trapped_q;

    always_comb begin
        case (sys_op_q)
            OP_ECALL:  trap_cause = ECALL_CAUSE;
            OP_EBREAK: trap_cause = EBREAK_CAUSE;
            default:   trap_cause = ILLEGAL_CAUSE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the async reset clears the whole operand latch too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sys_op_q  <= '0;
            funct3_q  <= '0;
            csr_sel_q <= '0;
            rs1_idx_q <= '0;
            rs1_val_q <= '0;
            pc_q      <= '0;
            old_q     <= '0;
            new_pc_q  <= '0;
            trapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sys_op_q  <= sys_op_d;
            funct3_q  <= funct3_d;
            csr_sel_q <= csr_sel_d;
            rs1_idx_q <= rs1_idx_d;
            rs1_val_q <= rs1_val_d;
            pc_q      <= pc_d;
            old_q     <= old_d;
            new_pc_q  <= new_pc_d;
            trapped_q <= trapped_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        sys_op_d  = sys_op_q;
        funct3_d  = funct3_q;
        csr_sel_d = csr_sel_q;
        rs1_idx_d = rs1_idx_q;
        rs1_val_d = rs1_val_q;
        pc_d      = pc_q;
        old_d     = old_q;
        new_pc_d  = new_pc_q;
        trapped_d = trapped_q;

        bus.done_o           = 1'b0;
        bus.rd_we_o          = 1'b0;
        bus.rd_data_o        = '0;
        bus.redirect_o       = 1'b0;
        bus.csr_addr_o       = '0;
        bus.csr_bus_o        = '0;
        bus.csr_read_o       = 1'b0;
        bus.csr_write_o      = 1'b0;
        bus.csr_write_type_o = '0;
        bus.csr_trap_o       = 1'b0;
        bus.csr_trap_cause_o = '0;
        bus.csr_ret_o        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    sys_op_d  = bus.sys_op_i;
                    funct3_d  = bus.funct3_i;
                    csr_sel_d = bus.csr_sel_i;
                    rs1_idx_d = bus.rs1_idx_i;
                    rs1_val_d = bus.rs1_val_i;
                    pc_d      = bus.pc_i;
                    old_d     = '0;
                    trapped_d = 1'b0;
                    case (bus.sys_op_i)
                        OP_CSR:  state_d = (bus.funct3_i[1:0] == 2'b00) ? S_TRAP : S_RD;
                        2'b11:   state_d = S_RET;
                        default: state_d = S_TRAP;
                    endcase
                end
            end

            S_RD: begin
                bus.csr_addr_o = csr_sel_q;
                bus.csr_read_o = 1'b1;
                old_d          = bus.csr_rdata_i;
                if (bus.csr_invalid_i) begin
                    state_d = S_TRAP;
                end else if (skip_wr) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WR;
                end
            end

            S_WR: begin
                bus.csr_addr_o       = csr_sel_q;
                bus.csr_write_o      = 1'b1;
                bus.csr_write_type_o = funct3_q[1:0];
                bus.csr_bus_o        = funct3_q[2] ? {27'b0, rs1_idx_q} : rs1_val_q;
                state_d              = S_DONE;
            end

            S_TRAP: begin
                bus.csr_trap_o       = 1'b1;
                bus.csr_trap_cause_o = trap_cause;
                bus.csr_bus_o        = pc_q;
                trapped_d            = 1'b1;
                state_d              = S_VEC;
            end

            // Vector and mepc fetches are address-only reads; csr_read stays
            // reserved for the instruction's own CSR access.
            S_VEC: begin
                bus.csr_addr_o = MTVEC_ADDR;
                new_pc_d       = bus.csr_rdata_i;
                state_d        = S_DONE;
            end

            S_RET: begin
                bus.csr_addr_o = MEPC_ADDR;
                bus.csr_ret_o  = 1'b1;
                new_pc_d       = bus.csr_rdata_i;
                state_d        = S_DONE;
            end

            S_DONE: begin
                bus.done_o     = 1'b1;
                bus.rd_we_o    = csr_ok;
                bus.rd_data_o  = csr_ok ? old_q : '0;
                bus.redirect_o = !csr_ok;
                state_d        = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.new_pc_o = new_pc_q;

endmodule

// File: tb/tb_csr_sequencer.sv
// Randomized self-checking bench for csr_sequencer against a transaction-level
// model that expands each instruction into its expected per-cycle strobe list.
module tb_csr_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_sequencer_if sif ();

    csr_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rd_we;
        logic        redirect;
        logic        read;
        logic        write;
        logic        trap;
        logic        ret;
        logic [1:0]  wtype;
        logic [4:0]  cause;
        logic [11:0] addr;
        logic [31:0] bus;
        logic [31:0] rd_data;
    } step_t;

    function automatic logic is_invalid(input logic [11:0] a);
        return a[11:6] == 6'h1F;
    endfunction

    // CSR-file environment: responds to the DUT and applies its writes/traps.
    logic [31:0] init_mem [4096];
    logic [31:0] env_mem  [4096];
    logic [31:0] ref_mem  [4096];
    logic        load;

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 4096; i++) env_mem[i] <= init_mem[i];
        end else begin
            if (sif.csr_write_o) begin
                case (sif.csr_write_type_o)
                    2'b01:   env_mem[sif.csr_addr_o] <= sif.csr_bus_o;
                    2'b10:   env_mem[sif.csr_addr_o] <= env_mem[sif.csr_addr_o] | sif.csr_bus_o;
                    2'b11:   env_mem[sif.csr_addr_o] <= env_mem[sif.csr_addr_o] & ~sif.csr_bus_o;
                    default: ;
                endcase
            end
            if (sif.csr_trap_o) begin
                env_mem[12'h341] <= sif.csr_bus_o;
                env_mem[12'h342] <= {27'b0, sif.csr_trap_cause_o};
            end
        end
    end

    assign sif.csr_rdata_i   = env_mem[sif.csr_addr_o];
    assign sif.csr_invalid_i = is_invalid(sif.csr_addr_o);

    function automatic step_t observe();
        step_t s;
        s.busy     = sif.busy_o;
        s.done     = sif.done_o;
        s.rd_we    = sif.rd_we_o;
        s.redirect = sif.redirect_o;
        s.read     = sif.csr_read_o;
        s.write    = sif.csr_write_o;
        s.trap     = sif.csr_trap_o;
        s.ret      = sif.csr_ret_o;
        s.wtype    = sif.csr_write_type_o;
        s.cause    = sif.csr_trap_cause_o;
        s.addr     = sif.csr_addr_o;
        s.bus      = sif.csr_bus_o;
        s.rd_data  = sif.rd_data_o;
        return s;
    endfunction

    // Reference model state
    step_t       exp_q[$];
    logic [31:0] model_new_pc;
    int          txn_id = 0;

    function automatic step_t busy_step();
        step_t s;
        s = '0;
        s.busy = 1'b1;
        return s;
    endfunction

    task automatic build(input logic [1:0] op, input logic [2:0] f3, input logic [11:0] sel,
                         input logic [4:0] idx, input logic [31:0] val, input logic [31:0] pc);
        step_t       s;
        logic        do_trap;
        logic        csr_ok;
        logic        skip;
        logic [4:0]  cause;
        logic [31:0] old;
        logic [31:0] wval;
        exp_q.delete();
        do_trap = 1'b0;
        csr_ok  = 1'b0;
        cause   = 5'd0;
        old     = 32'd0;
        case (op)
            2'b00: begin
                if (f3[1:0] == 2'b00) begin
                    do_trap = 1'b1;
                    cause   = 5'd2;
                end else begin
                    s = busy_step(); s.read = 1'b1; s.addr = sel;
                    exp_q.push_back(s);
                    if (is_invalid(sel)) begin
                        do_trap = 1'b1;
                        cause   = 5'd2;
                    end else begin
                        csr_ok = 1'b1;
                        old    = ref_mem[sel];
`ifdef CSR_RS1_ZERO_SKIP_EN
                        skip = f3[1] && (idx == 5'd0);
`else
                        skip = 1'b0;
`endif
                        if (!skip) begin
                            wval = f3[2] ? {27'b0, idx} : val;
                            s = busy_step(); s.write = 1'b1; s.wtype = f3[1:0];
                            s.addr = sel; s.bus = wval;
                            exp_q.push_back(s);
                            if (f3[1:0] == 2'b01)      ref_mem[sel] = wval;
                            else if (f3[1:0] == 2'b10) ref_mem[sel] = old | wval;
                            else                       ref_mem[sel] = old & ~wval;
                        end
                    end
                end
            end
            2'b01: begin do_trap = 1'b1; cause = 5'd11; end
            2'b10: begin do_trap = 1'b1; cause = 5'd3;  end
            default: begin
                s = busy_step(); s.ret = 1'b1; s.addr = 12'h341;
                exp_q.push_back(s);
                model_new_pc = ref_mem[12'h341];
            end
        endcase
        if (do_trap) begin
            s = busy_step(); s.trap = 1'b1; s.cause = cause; s.bus = pc;
            exp_q.push_back(s);
            ref_mem[12'h341] = pc;
            ref_mem[12'h342] = {27'b0, cause};
            s = busy_step(); s.addr = 12'h305;
            exp_q.push_back(s);
            model_new_pc = ref_mem[12'h305];
        end
        s = busy_step(); s.done = 1'b1; s.rd_we = csr_ok; s.redirect = !csr_ok;
        s.rd_data = csr_ok ? old : 32'd0;
        exp_q.push_back(s);
    endtask

    task automatic scramble_inputs();
        sif.start_i   = 1'($urandom_range(0, 1));
        sif.sys_op_i  = 2'($urandom);
        sif.funct3_i  = 3'($urandom);
        sif.csr_sel_i = 12'($urandom);
        sif.rs1_idx_i = 5'($urandom);
        sif.rs1_val_i = $urandom;
        sif.pc_i      = $urandom;
    endtask

    // Called at a negedge; presents the request, then checks every cycle
    // through done plus one trailing idle cycle.
    task automatic run_txn(input logic [1:0] op, input logic [2:0] f3, input logic [11:0] sel,
                           input logic [4:0] idx, input logic [31:0] val, input logic [31:0] pc,
                           input bit noise);
        step_t got;
        int    n;
        txn_id++;
        build(op, f3, sel, idx, val, pc);
        n = exp_q.size();
        sif.start_i   = 1'b1;
        sif.sys_op_i  = op;
        sif.funct3_i  = f3;
        sif.csr_sel_i = sel;
        sif.rs1_idx_i = idx;
        sif.rs1_val_i = val;
        sif.pc_i      = pc;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            got = observe();
            check($sformatf("t%0d_op%0d_cyc%0d", txn_id, op, k + 1), 128'(got), 128'(exp_q[k]));
            if (k == n - 1) begin
                check($sformatf("t%0d_new_pc", txn_id), 128'(sif.new_pc_o), 128'(model_new_pc));
                sif.start_i = 1'b0;
            end else if (noise) begin
                scramble_inputs();
            end else begin
                sif.start_i = 1'b0;
            end
        end
        @(negedge clk);
        check($sformatf("t%0d_idle", txn_id), 128'(observe()), 128'(step_t'('0)));
    endtask

    logic [11:0] sels [8];

    initial begin
        step_t s;
        sels = '{12'h340, 12'h300, 12'h305, 12'h341, 12'h342, 12'h7C0, 12'h7FF, 12'h001};
        rst  = 1'b1;
        load = 1'b1;
        sif.start_i   = 1'b0;
        sif.sys_op_i  = '0;
        sif.funct3_i  = '0;
        sif.csr_sel_i = '0;
        sif.rs1_idx_i = '0;
        sif.rs1_val_i = '0;
        sif.pc_i      = '0;
        for (int i = 0; i < 4096; i++) init_mem[i] = $urandom;
        init_mem[12'h340] = 32'h0;
        init_mem[12'h305] = 32'h4;
        for (int i = 0; i < 4096; i++) ref_mem[i] = init_mem[i];
        model_new_pc = 32'h0;

        repeat (2) @(negedge clk);
        check("reset_outputs", 128'(observe()), 128'(step_t'('0)));
        check("reset_new_pc", 128'(sif.new_pc_o), 128'(32'h0));
        load = 1'b0;
        rst  = 1'b0;

        // Directed scenarios
        run_txn(2'b00, 3'b001, 12'h340, 5'd1,  32'hDEADBEEF, 32'h0,   1'b0);
        run_txn(2'b00, 3'b010, 12'h300, 5'd0,  32'h12345678, 32'h0,   1'b0);
        run_txn(2'b00, 3'b001, 12'h7C0, 5'd3,  32'h0,        32'h100, 1'b0);
        run_txn(2'b01, 3'b000, 12'h000, 5'd0,  32'h0,        32'h200, 1'b0);
        run_txn(2'b11, 3'b000, 12'h000, 5'd0,  32'h0,        32'h0,   1'b0);
        run_txn(2'b10, 3'b000, 12'h000, 5'd0,  32'h0,        32'h300, 1'b1);
        run_txn(2'b00, 3'b100, 12'h340, 5'd7,  32'h0,        32'h400, 1'b1);
        run_txn(2'b00, 3'b111, 12'h340, 5'd0,  32'h0,        32'h0,   1'b1);
        run_txn(2'b00, 3'b101, 12'h340, 5'd31, 32'h0,        32'h0,   1'b1);

        // Randomized traffic with start re-pulsed and operands scrambled while busy
        for (int t = 0; t < 300; t++) begin
            run_txn(2'($urandom), 3'($urandom), sels[$urandom_range(0, 7)],
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                    $urandom, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, 1'b1);
        end

        // Reset in WR: abort with no write, outputs cleared before the next edge
        sif.start_i   = 1'b1;
        sif.sys_op_i  = 2'b00;
        sif.funct3_i  = 3'b001;
        sif.csr_sel_i = 12'h340;
        sif.rs1_idx_i = 5'd9;
        sif.rs1_val_i = 32'hA5A5_0F0F;
        sif.pc_i      = 32'h0;
        @(negedge clk);
        s = busy_step(); s.read = 1'b1; s.addr = 12'h340;
        check("abort_rd", 128'(observe()), 128'(s));
        @(negedge clk);
        s = busy_step(); s.write = 1'b1; s.wtype = 2'b01; s.addr = 12'h340; s.bus = 32'hA5A5_0F0F;
        check("abort_wr", 128'(observe()), 128'(s));
        sif.start_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", 128'(observe()), 128'(step_t'('0)));
        check("abort_new_pc", 128'(sif.new_pc_o), 128'(32'h0));
        model_new_pc = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        // First edge after release must accept; CSRRS reads back the unwritten value
        run_txn(2'b00, 3'b010, 12'h340, 5'd2, 32'h0000_0100, 32'h0, 1'b0);
        run_txn(2'b11, 3'b000, 12'h000, 5'd0, 32'h0, 32'h0, 1'b0);
        for (int t = 0; t < 20; t++) begin
            run_txn(2'($urandom), 3'($urandom), sels[$urandom_range(0, 7)],
                    5'($urandom), $urandom, {$urandom_range(0, 32'h3FFFFFFF), 2'b00}, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
